// File: rtl/vga_pattern_gen_if.sv
// Pixel-stage bus: timing strobes and pattern controls in, pin-aligned video out.
interface vga_pattern_gen_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        video_on_in;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [15:0] frame_cnt;

  modport master (
    output hsync_in, vsync_in, video_on_in, mode, solid_rgb,
    input  hsync, vsync, rgb, frame_cnt
  );

  modport slave (
    input  hsync_in, vsync_in, video_on_in, mode, solid_rgb,
    output hsync, vsync, rgb, frame_cnt
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA pixel-colour stage: recovers x/y from the timing strobes, renders one of
// four test patterns and re-times sync so colour and sync reach the pins together.
module vga_pattern_gen #(
  parameter int unsigned HVID            = 640,
  parameter int unsigned VVID            = 480,
  parameter int unsigned BAR_W           = 16,
  parameter int unsigned BAR_STEP        = 4,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clk_25,
  input  logic             n_rst,
  vga_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_MOVING  = 2'd3
  } mode_e;

  localparam logic [9:0]  X_MAX      = '1;
  localparam logic [9:0]  Y_MAX      = 10'(VVID);
  localparam logic [9:0]  BAR_LAST   = 10'(HVID / 8 - 1);
  localparam logic [9:0]  STEP_L     = 10'(BAR_STEP);
  localparam logic [10:0] BAR_W_L    = 11'(BAR_W);
  localparam logic [10:0] BAR_LIMIT  = 11'(HVID - BAR_W);

  logic        vid_q;
  logic        vs_q;
  logic        vs_rise;
  logic        vid_fall;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [2:0]  bar_idx;
  logic [9:0]  bar_cnt;
  logic [9:0]  bar_pos;
  mode_e       mode_q;
  logic [15:0] frame_cnt_q;
  logic [10:0] bar_end;
  logic [11:0] pix;
  logic [11:0] rgb_q;
  logic        hsync_q;
  logic        vsync_q;

  assign vs_rise  = bus.vsync_in & ~vs_q;
  assign vid_fall = vid_q & ~bus.video_on_in;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Registered copies of video_on/vsync for edge detection.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      vid_q <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      vid_q <= bus.video_on_in;
      vs_q  <= bus.vsync_in;
    end
  end

  // x: length of the current video_on run so far, saturating.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst)                  x <= '0;
    else if (!bus.video_on_in)   x <= '0;
    else if (x != X_MAX)         x <= x + 10'd1;
  end

  // y: lines since vsync; a vsync rise beats a same-cycle line end.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst)                       y <= '0;
    else if (vs_rise)                 y <= '0;
    else if (vid_fall && y != Y_MAX)  y <= y + 10'd1;
  end

  // Colour-bar index tracked alongside x so no divider is needed; clamps at the last bar.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      bar_idx <= '0;
      bar_cnt <= '0;
    end else if (!bus.video_on_in) begin
      bar_idx <= '0;
      bar_cnt <= '0;
    end else if (bar_cnt == BAR_LAST) begin
      bar_cnt <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_cnt <= bar_cnt + 10'd1;
    end
  end

  // Once-per-frame updates: mode latch, frame counter, moving-bar position.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      mode_q      <= MODE_SOLID;
      frame_cnt_q <= '0;
      bar_pos     <= '0;
    end else if (vs_rise) begin
      mode_q      <= mode_e'(bus.mode);
      frame_cnt_q <= frame_cnt_q + 16'd1;
      if ({1'b0, bar_pos} + {1'b0, STEP_L} > BAR_LIMIT) bar_pos <= '0;
      else                                             bar_pos <= bar_pos + STEP_L;
    end
  end

  // Pattern colour for the current input cycle; black outside active video.
  always_comb begin
    bar_end = {1'b0, bar_pos} + BAR_W_L;
    pix     = '0;
    if (bus.video_on_in) begin
      case (mode_q)
        MODE_SOLID:   pix = bus.solid_rgb;
        MODE_BARS:    pix = bar_colour(bar_idx);
        MODE_CHECKER: pix = (x[5] ^ y[5]) ? 12'hFFF : 12'h000;
        MODE_MOVING:  pix = (x >= bar_pos && {1'b0, x} < bar_end) ? 12'hFFF : 12'h00F;
        default:      pix = '0;
      endcase
    end
  end

  // Single output register stage keeps rgb and both syncs on the same edge.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      rgb_q   <= '0;
      hsync_q <= SYNC_ACTIVE_LOW;
      vsync_q <= SYNC_ACTIVE_LOW;
    end else begin
      rgb_q   <= pix;
      hsync_q <= bus.hsync_in ^ SYNC_ACTIVE_LOW;
      vsync_q <= bus.vsync_in ^ SYNC_ACTIVE_LOW;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: per-cycle golden model plus pixel table.
module tb_vga_pattern_gen;

  localparam int HVID     = 640;
  localparam int VVID     = 480;
  localparam int BAR_W    = 16;
  localparam int BAR_STEP = 4;
  localparam bit SAL      = 1'b1;
  localparam int NPOS     = (HVID - BAR_W) / BAR_STEP + 1;

  logic clk_25 = 1'b0;
  logic n_rst  = 1'b0;
  always #20 clk_25 = ~clk_25;

  vga_pattern_gen_if bus();

  vga_pattern_gen #(
    .HVID(HVID), .VVID(VVID), .BAR_W(BAR_W), .BAR_STEP(BAR_STEP), .SYNC_ACTIVE_LOW(SAL)
  ) dut (
    .clk_25(clk_25),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    int          tag;
    int          line;
    int          px;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[$];

  logic [11:0] cap [256][1152];
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic [1:0]  mode_r  = 2'd0;
  logic [11:0] solid_r = 12'h000;
  int          sw_line = -1;
  logic [1:0]  sw_mode = 2'd0;
  int          rst_line = -1;
  int          rst_hold = 0;
  int          n_frames = 0;
  int          hs_low, vs_low;

  // golden model state, in terms of runs, lines and frames
  int          run, lines, frames, mode_f;
  logic        pv, pvs;
  bit          dc = 1'b1;
  logic [11:0] e_rgb;
  logic        e_hs, e_vs;
  logic [15:0] e_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pix(int xx, int yy, int m, logic [11:0] solid, int bar);
    int idx;
    case (m)
      0: return solid;
      1: begin
        idx = xx / (HVID / 8);
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      2: return ((((xx / 32) + (yy / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      default: return (xx >= bar && xx < bar + BAR_W) ? 12'hFFF : 12'h00F;
    endcase
  endfunction

  task automatic model_step(input logic hs, input logic vs, input logic von,
                            input logic [1:0] m, input logic [11:0] solid);
    int xx, yy;
    if (!n_rst) begin
      run = 0; lines = 0; frames = 0; mode_f = 0; pv = 1'b0; pvs = 1'b0; dc = 1'b1;
      e_rgb = '0; e_hs = SAL; e_vs = SAL; e_fc = '0;
      return;
    end
    xx = (run > 1023) ? 1023 : run;
    yy = (lines > VVID) ? VVID : lines;
    e_rgb = von ? ref_pix(xx, yy, mode_f, solid, BAR_STEP * (frames % NPOS)) : 12'h000;
    e_hs = hs ^ SAL;
    e_vs = vs ^ SAL;
    if (vs && !pvs) begin
      frames++; mode_f = int'(m); lines = 0; dc = 1'b0;
    end else if (pv && !von) begin
      lines++;
    end
    run = von ? run + 1 : 0;
    pv  = von;
    pvs = vs;
    e_fc = 16'(frames % 65536);
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic von);
    bit dcn;
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) n_rst = 1'b1;
    end
    bus.hsync_in = hs; bus.vsync_in = vs; bus.video_on_in = von;
    bus.mode = mode_r; bus.solid_rgb = solid_r;
    @(posedge clk_25);
    dcn = dc;
    model_step(hs, vs, von, mode_r, solid_r);
    #1;
    if (!dcn || !n_rst) check("rgb", 32'(bus.rgb), 32'(e_rgb));
    check("hsync", 32'(bus.hsync), 32'(e_hs));
    check("vsync", 32'(bus.vsync), 32'(e_vs));
    check("frame_cnt", 32'(bus.frame_cnt), 32'(e_fc));
  endtask

  task automatic do_reset();
    #5 n_rst = 1'b0;
    #1;
    check("async_rst_rgb", 32'(bus.rgb), 32'h0);
    check("async_rst_hsync", 32'(bus.hsync), 32'(SAL));
    check("async_rst_vsync", 32'(bus.vsync), 32'(SAL));
    check("async_rst_fc", 32'(bus.frame_cnt), 32'h0);
    n_frames = 0;
    rst_hold = 4;
  endtask

  // vsl sync lines, one back-porch line, nact active lines, one front-porch line
  task automatic frame(input int vsl, input int nact, input int act,
                       input int fp, input int hw, input int bp);
    int len, total, al;
    bit vs_l, act_l, von, hs;
    len   = act + fp + hw + bp;
    total = vsl + 1 + nact + 1;
    n_frames++;
    for (int l = 0; l < total; l++) begin
      vs_l  = (l < vsl);
      al    = l - vsl - 1;
      act_l = (al >= 0 && al < nact);
      if (act_l && al == sw_line) mode_r = sw_mode;
      for (int p = 0; p < len; p++) begin
        von = act_l && (p < act);
        hs  = (p >= act + fp) && (p < act + fp + hw);
        cyc(hs, vs_l, von);
        if (!bus.hsync) hs_low++;
        if (!bus.vsync) vs_low++;
        if (von && al < 256 && p < 1152) cap[al][p] = bus.rgb;
        if (act_l && al == rst_line && p == 50) do_reset();
      end
    end
    check("frame_cnt_step", 32'(bus.frame_cnt), 32'(n_frames % 65536));
  endtask

  task automatic quick_vsync();
    n_frames++;
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("frame_cnt_step", 32'(bus.frame_cnt), 32'(n_frames % 65536));
  endtask

  task automatic check_table(input int tag);
    foreach (tbl[i])
      if (tbl[i].tag == tag)
        check(tbl[i].name, 32'(cap[tbl[i].line][tbl[i].px]), 32'(tbl[i].exp));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    tbl.push_back('{"bars_p0",     1, 0,   0,    12'hFFF});
    tbl.push_back('{"bars_p79",    1, 0,   79,   12'hFFF});
    tbl.push_back('{"bars_p80",    1, 0,   80,   12'hFF0});
    tbl.push_back('{"bars_p639",   1, 0,   639,  12'h000});
    tbl.push_back('{"bars_l3_p400",1, 3,   400,  12'hF00});
    tbl.push_back('{"chk_31_0",    2, 0,   31,   12'h000});
    tbl.push_back('{"chk_32_0",    2, 0,   32,   12'hFFF});
    tbl.push_back('{"chk_32_32",   2, 32,  32,   12'h000});
    tbl.push_back('{"chk_0_32",    2, 32,  0,    12'hFFF});
    tbl.push_back('{"mbar_p0",     3, 0,   0,    12'h00F});
    tbl.push_back('{"mbar_p623",   3, 0,   623,  12'h00F});
    tbl.push_back('{"mbar_p624",   3, 0,   624,  12'hFFF});
    tbl.push_back('{"mbar_p639",   3, 0,   639,  12'hFFF});
    tbl.push_back('{"sw_l205_p10", 4, 205, 10,   12'hFFF});
    tbl.push_back('{"sw_l205_p85", 4, 205, 85,   12'hFF0});
    tbl.push_back('{"long_bar_480",6, 0,   480,  12'h00F});
    tbl.push_back('{"long_bar_700",6, 0,   700,  12'h000});
    tbl.push_back('{"long_bar_1099",6,0,   1099, 12'h000});
    tbl.push_back('{"long_chk_960",7, 0,   960,  12'h000});
    tbl.push_back('{"long_chk_1024",7,0,   1024, 12'hFFF});
    tbl.push_back('{"long_chk_1099",7,0,   1099, 12'hFFF});

    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.video_on_in = 1'b0;
    bus.mode = 2'd0; bus.solid_rgb = '0;

    // power-on reset
    rst_hold = 3;
    cyc(1'b1, 1'b1, 1'b1);
    check("reset_rgb", 32'(bus.rgb), 32'h0);
    check("reset_hsync", 32'(bus.hsync), 32'(SAL));
    check("reset_vsync", 32'(bus.vsync), 32'(SAL));
    check("reset_fc", 32'(bus.frame_cnt), 32'h0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    // controller-like timing, colour bars
    mode_r = 2'd1;
    hs_low = 0; vs_low = 0;
    frame(2, 4, 640, 16, 96, 48);
    check("hsync_low_cycles", 32'(hs_low), 32'(96 * 8));
    check("vsync_low_cycles", 32'(vs_low), 32'(2 * 800));
    check_table(1);

    // checkerboard
    mode_r = 2'd2;
    frame(1, 34, 64, 2, 4, 2);
    check_table(2);

    // moving bar across the wrap point
    mode_r = 2'd3;
    while (n_frames < 160) begin
      f = n_frames + 1;
      if (f == 50 || f == 100 || f == 150 || (f >= 155 && f <= 158)) begin
        frame(1, 1, 640, 2, 4, 2);
        if (f == 156) check_table(3);
      end else begin
        quick_vsync();
      end
    end

    // mode change mid-frame only takes effect at the next vsync
    mode_r = 2'd1;
    frame(1, 4, 88, 2, 4, 2);
    sw_line = 200; sw_mode = 2'd2;
    frame(1, 210, 88, 2, 4, 2);
    sw_line = -1;
    check_table(4);
    frame(1, 34, 64, 2, 4, 2);
    check_table(2);

    // over-long active runs: x saturates, bar index clamps
    mode_r = 2'd1;
    frame(1, 1, 1100, 2, 4, 2);
    check_table(6);
    mode_r = 2'd2;
    frame(1, 1, 1100, 2, 4, 2);
    check_table(7);
    // more lines than VVID: y saturates
    frame(1, 520, 1, 2, 4, 2);

    // randomized strobes and controls
    for (int i = 0; i < 3000; i++) begin
      solid_r = 12'($urandom);
      if ($urandom_range(0, 99) == 0) mode_r = 2'($urandom);
      cyc(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) < 2),
          1'($urandom_range(0, 15) != 0));
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    n_frames = frames;
    for (int i = 0; i < 6; i++) begin
      mode_r  = 2'($urandom);
      solid_r = 12'($urandom);
      frame(1, $urandom_range(1, 3), $urandom_range(1, 200), 2, 4, 2);
    end

    // asynchronous reset in the middle of line 100, then a clean frame
    mode_r = 2'd1;
    rst_line = 100;
    frame(1, 110, 64, 2, 4, 2);
    rst_line = -1;
    frame(1, 4, 640, 2, 4, 2);
    check_table(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-colour stage directly downstream of the VGA timing controller.
- Consumes the controller's registered hsync/vsync/video_on strobes and reconstructs pixel coordinates from them.
- Generates one of four test patterns as 12-bit RGB (4:4:4), and re-times sync so RGB and sync leave the block aligned to the DAC/pins.
- Also applies the final sync polarity.

Parameters:
HVID, 640, active pixels per line; colour-bar and moving-bar geometry derive from it
VVID, 480, active lines per frame; bounds the y counter
BAR_W, 16, moving-bar width in pixels
BAR_STEP, 4, moving-bar advance in pixels per frame
SYNC_ACTIVE_LOW, 1, 1: output syncs are inverted (active-low at pins); 0: passed at input polarity

Ports:
clk_25  input  1  pixel clock, 25 MHz
n_rst  input  1  asynchronous active-low reset
hsync_in  input  1  controller hsync, active-high pulse
vsync_in  input  1  controller vsync, active-high pulse
video_on_in  input  1  controller active-region flag
mode  input  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 moving bar
solid_rgb  input  12  colour for mode 0, {R[3:0],G[3:0],B[3:0]}
hsync  output  1  re-timed hsync at output polarity
vsync  output  1  re-timed vsync at output polarity
rgb  output  12  pixel colour, 0 outside active video
frame_cnt  output  16  frames since reset, for debug/LED

Behaviour:
- Reset is asynchronous, active-low, on n_rst; clock is clk_25.

Reset values:
- rgb = 0, frame_cnt = 0, x = y = 0, bar_pos = 0, mode_q = 0.
- hsync = vsync = inactive level: 1 if SYNC_ACTIVE_LOW else 0.

Coordinate recovery (10-bit x, y):
- x = count of consecutive prior video_on_in-high cycles in the current run.
- x clears on any cycle where video_on_in = 0, and saturates at 1023.
- y increments on each video_on_in falling edge (1 then 0, tracked via a registered copy).
- y clears on each vsync_in rising edge; if both occur in the same cycle, clear wins. y saturates at VVID.

Frame events, all on vsync_in rising edge (0 to 1):
- mode_q <= mode. Mode is therefore sampled once per frame, so no tearing on mid-frame changes.
- frame_cnt += 1, wrapping at 16 bits.
- Moving bar: if bar_pos + BAR_STEP > HVID - BAR_W then bar_pos <= 0, else bar_pos <= bar_pos + BAR_STEP.

Pixel colour, computed from (x, y, mode_q) in the cycle video_on_in = 1:
- Mode 0: solid_rgb, sampled live.
- Mode 1: idx = min(x / (HVID/8), 7). idx 0..7 maps to FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Implement with a per-line bar counter plus an in-bar counter; no divider.
- Mode 2: FFF if x[5] XOR y[5], else 000 (32x32 squares).
- Mode 3: FFF if bar_pos <= x < bar_pos + BAR_W, else 00F.

Latency and alignment:
- Fixed 1 cycle. Inputs sampled at edge t appear on rgb/hsync/vsync at edge t+1.
- rgb = 0 whenever the delayed video_on is 0.
- hsync = hsync_in delayed 1, XOR SYNC_ACTIVE_LOW; vsync likewise.
- Sync and rgb must never be skewed relative to each other.

Boundary cases:
- Mode change mid-frame: no visible effect until the next vsync rising edge.
- Reset mid-line: outputs go to reset values immediately (asynchronous).
  - After release, x restarts at the next video_on_in rise.
  - y counts from 0 until the first vsync; garbage in a partial frame is acceptable.
- vsync_in held high for several cycles: exactly one frame event.
- video_on_in runs longer than HVID: x saturates; bar index clamps to 7.

Test Plan:
- Reset then release; drive controller-like timing (800x525, active 640x480): rgb = 000 in every blanking cycle; hsync = 0 exactly 96 cycles per line and vsync = 0 for 2 lines with SYNC_ACTIVE_LOW = 1; each one cycle after its input.
- mode = 1, one full frame: line 0 pixel 0 = FFF, pixel 79 = FFF, pixel 80 = FF0, pixel 639 = 000; every line identical.
- mode = 2: pixel (31,0) = 000, (32,0) = FFF, (32,32) = 000, (0,32) = FFF.
- mode = 3 for 160 frames: bar_pos on frame n = 4n for n ≤ 156; at bar_pos = 624 the next frame wraps to 0; pixel 623 = 00F and 624..639 = FFF when bar_pos = 624.
- Mode switched 1 to 2 at line 200: remainder of frame stays bars; next frame is checkerboard; frame_cnt increments by exactly 1 per vsync pulse.
- Assert n_rst mid-line 100 for 3 cycles: rgb = 000 and syncs inactive within the same cycle; after the next vsync, frame output matches the golden model exactly.
